// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port SRAM macro between an instruction-fetch port (read
// only) and a data port (read/write). Data requests win conflicts, except that
// the fetch port wins once it has lost STARVE_MAX conflict cycles in a row.
// The single outstanding read is tracked so that the SRAM read data, which
// arrives one cycle after the grant, is steered back to the requester that
// issued it.
//
// Parameters:
//   AW         SRAM word-address width (low AW bits of the 30-bit addresses)
//   BW         data width
//   STARVE_MAX consecutive lost conflicts before fetch wins (1..15)
//
// Ports:
//   CLK, RSTN                 clock (rising edge), synchronous active-low reset
//   I_REQ/I_ADDR              fetch request and word address
//   I_GNT                     fetch request accepted this cycle
//   I_RVALID/I_RDATA          fetch read return (1 cycle after grant)
//   D_REQ/D_RW/D_ADDR/D_WDATA data request (D_RW=1 write), address, write data
//   D_GNT                     data request accepted this cycle
//   D_RVALID/D_RDATA          data read return (1 cycle after grant)
//   M_CSN/M_WEN/M_A/M_DI      SRAM strobes (active low), address, write data
//   M_DOUT                    SRAM read data, valid the cycle after a read
//   CONFLICT_CNT              saturating count of cycles with both requesting
//                             (only when ARB_PERF_CNT_EN is defined)
//
// Optional feature macro: ARB_PERF_CNT_EN
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned AW         = 10,
  parameter int unsigned BW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  // fetch port
  input  logic          I_REQ,
  input  logic [29:0]   I_ADDR,
  output logic          I_GNT,
  output logic          I_RVALID,
  output logic [BW-1:0] I_RDATA,
  // data port
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [29:0]   D_ADDR,
  input  logic [BW-1:0] D_WDATA,
  output logic          D_GNT,
  output logic          D_RVALID,
  output logic [BW-1:0] D_RDATA,
`ifdef ARB_PERF_CNT_EN
  output logic [15:0]   CONFLICT_CNT,
`endif
  // SRAM macro
  output logic          M_CSN,
  output logic          M_WEN,
  output logic [AW-1:0] M_A,
  output logic [BW-1:0] M_DI,
  input  logic [BW-1:0] M_DOUT
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_I    = 2'd1,
    RD_D    = 2'd2
  } rd_owner_t;

  logic [3:0] starve_cnt;
  rd_owner_t  rd_owner;

  logic both_req;
  logic starved;
  logic i_win;
  logic d_win;
  logic d_wr;

  // Address bits above AW-1 alias onto the SRAM and are intentionally dropped.
  generate
    if (AW < 30) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^{I_ADDR[29:AW], D_ADDR[29:AW]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration (combinational from REQs and registered starve_cnt)
  // ---------------------------------------------------------------------------
  always_comb begin
    both_req = I_REQ & D_REQ;
    starved  = (starve_cnt == STARVE_LIM);
    // No grants at all while reset is held, whatever the requesters do.
    i_win    = RSTN & I_REQ & (~D_REQ | starved);
    d_win    = RSTN & D_REQ & ~i_win;
    d_wr     = d_win & D_RW;
  end

  assign I_GNT = i_win;
  assign D_GNT = d_win;

  // ---------------------------------------------------------------------------
  // SRAM drive in the grant cycle; idle values otherwise
  // ---------------------------------------------------------------------------
  always_comb begin
    M_CSN = 1'b1;
    M_WEN = 1'b1;
    M_A   = '0;
    M_DI  = '0;
    if (i_win) begin
      M_CSN = 1'b0;
      M_A   = I_ADDR[AW-1:0];
    end else if (d_win) begin
      M_CSN = 1'b0;
      M_A   = D_ADDR[AW-1:0];
      if (d_wr) begin
        M_WEN = 1'b0;
        M_DI  = D_WDATA;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter and read-return owner
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      starve_cnt <= '0;
      rd_owner   <= RD_NONE;
    end else begin
      // A lost conflict is the only way to advance; any fetch grant or an
      // idle fetch port restarts the streak.
      if (!I_REQ || i_win) begin
        starve_cnt <= '0;
      end else if (both_req && d_win && (starve_cnt < STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (i_win) begin
        rd_owner <= RD_I;
      end else if (d_win && !D_RW) begin
        rd_owner <= RD_D;
      end else begin
        rd_owner <= RD_NONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read return steering
  // ---------------------------------------------------------------------------
  // Gating with RSTN drops the return of a read whose data cycle coincides
  // with reset being asserted; the owner is cleared at the following edge.
  always_comb begin
    I_RVALID = RSTN & (rd_owner == RD_I);
    D_RVALID = RSTN & (rd_owner == RD_D);
    I_RDATA  = I_RVALID ? M_DOUT : '0;
    D_RDATA  = D_RVALID ? M_DOUT : '0;
  end

`ifdef ARB_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating conflict counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      CONFLICT_CNT <= '0;
    end else if (both_req && (CONFLICT_CNT != 16'hFFFF)) begin
      CONFLICT_CNT <= CONFLICT_CNT + 16'd1;
    end
  end
`endif

endmodule
